// File: rtl/leb128_pkg.sv
// Shared definitions for the LEB128 encode/decode datapath.
// Holds the group geometry, the byte-index type and the stream state encoding.
package leb128_pkg;

    localparam int LEB128_GROUP_W  = 7;
    localparam int LEB128_CONT_BIT = 7;

    typedef logic [3:0] leb128_idx_t;

    typedef enum logic {
        LEB_IDLE,
        LEB_EMIT
    } leb_state_e;

    // Number of 7-bit groups needed to carry a value of the given width.
    function automatic int leb128_max_bytes(input int width);
        return (width + LEB128_GROUP_W - 1) / LEB128_GROUP_W;
    endfunction

endpackage

// File: rtl/leb128_group_step.sv
// One LEB128 encoding step: splits the pending value into the low 7-bit group
// and the remainder, and decides whether this group terminates the encoding.
module leb128_group_step
    import leb128_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]         shift_reg,
    input  logic                      signed_mode,
    input  leb128_idx_t               idx,
    output logic [LEB128_GROUP_W-1:0] g,
    output logic [DATA_W-1:0]         rem,
    output logic                      last
);

    localparam int MAX_BYTES = leb128_max_bytes(DATA_W);

    logic signed [DATA_W-1:0] shift_signed;
    logic [DATA_W-1:0]        rem_arith;
    logic [DATA_W-1:0]        rem_logic;
    logic                     forced_last;

    // The arithmetic shift is kept in its own signed assignment so the
    // surrounding mode mux cannot coerce it back to a logical shift.
    assign shift_signed = shift_reg;
    assign rem_arith    = shift_signed >>> LEB128_GROUP_W;
    assign rem_logic    = shift_reg >> LEB128_GROUP_W;
    assign forced_last  = (idx == leb128_idx_t'(MAX_BYTES - 1));

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        g    = shift_reg[LEB128_GROUP_W-1:0];
        rem  = rem_logic;
        last = forced_last || (rem_logic == '0);
        if (signed_mode) begin
            rem  = rem_arith;
            last = forced_last
                || ((rem_arith == '0) && !g[LEB128_GROUP_W-1])
                || ((rem_arith == '1) &&  g[LEB128_GROUP_W-1]);
        end
    end

endmodule

// File: rtl/leb128_encode_stream.sv
// Sequential LEB128 encoder: takes one integer per handshake and streams its
// unsigned or signed LEB128 bytes, least significant group first.
module leb128_encode_stream
    import leb128_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] value_in,
    input  logic              signed_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic [3:0]        out_idx
);

    leb_state_e               state, state_nxt;
    logic [DATA_W-1:0]        shift_reg, shift_nxt;
    logic                     mode_q, mode_nxt;
    leb128_idx_t              idx, idx_nxt;

    logic [LEB128_GROUP_W-1:0] g;
    logic [DATA_W-1:0]         rem;
    logic                      last;
    logic                      out_fire;
    logic                      accept;

    leb128_group_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .shift_reg   (shift_reg),
        .signed_mode (mode_q),
        .idx         (idx),
        .g           (g),
        .rem         (rem),
        .last        (last)
    );

    // All byte-side outputs decode only registered state, so they hold steady
    // for as long as the downstream stalls.
    assign out_valid = (state == LEB_EMIT);
    assign out_last  = out_valid && last;
    assign out_byte  = out_valid ? {~last, g} : 8'h00;
    assign out_idx   = idx;
    assign out_fire  = out_valid && out_ready;
    // Accepting during the final-byte handshake keeps back-to-back values bubble-free.
    assign in_ready  = !out_valid || (out_fire && last);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        mode_nxt  = mode_q;
        idx_nxt   = idx;
        if (out_fire) begin
            if (last) begin
                state_nxt = LEB_IDLE;
            end else begin
                shift_nxt = rem;
                idx_nxt   = idx + leb128_idx_t'(1);
            end
        end
        if (accept) begin
            state_nxt = LEB_EMIT;
            shift_nxt = value_in;
            mode_nxt  = signed_mode;
            idx_nxt   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LEB_IDLE;
            shift_reg <= '0;
            mode_q    <= 1'b0;
            idx       <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            mode_q    <= mode_nxt;
            idx       <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_leb128_encode_stream.sv
// Self-checking bench for leb128_encode_stream (DATA_W=32): table-driven
// encodings plus hand-written backpressure, back-to-back and reset sequences.
module tb_leb128_encode_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value_in;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [3:0]  out_idx;

    int checks = 0;
    int errors = 0;

    leb128_encode_stream #(
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .value_in    (value_in),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_byte    (out_byte),
        .out_last    (out_last),
        .out_idx     (out_idx)
    );

    always #5 clk = ~clk;

    // Byte k of the expected encoding lives in bytes[8k+7:8k].
    typedef struct {
        logic [31:0] value;
        logic        sgn;
        int          n;
        logic [39:0] bytes;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference LEB128 decoder used for the round-trip check.
    function automatic logic [31:0] decode(input logic [39:0] bytes, input int n, input logic sgn);
        logic [63:0] r;
        logic [7:0]  b;
        int          sh;
        r  = '0;
        b  = '0;
        sh = 0;
        for (int k = 0; k < n; k++) begin
            b  = bytes[8*k +: 8];
            r  = r | (64'(b[6:0]) << sh);
            sh = sh + 7;
        end
        if (sgn && b[6] && sh < 64) r = r | (~64'd0 << sh);
        return r[31:0];
    endfunction

    // Called 1 time unit after a rising edge with the DUT idle.
    task automatic run_vec(input vec_t v, input int id);
        logic [39:0] got;
        logic [7:0]  exp_b;
        got = '0;
        check($sformatf("v%0d idle in_ready", id), 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        value_in    = v.value;
        signed_mode = v.sgn;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        value_in    = $urandom;
        signed_mode = 1'($urandom_range(0, 1));
        for (int k = 0; k < v.n; k++) begin
            exp_b = v.bytes[8*k +: 8];
            check($sformatf("v%0d b%0d out_valid", id, k), 64'(out_valid), 64'd1);
            check($sformatf("v%0d b%0d out_byte", id, k), 64'(out_byte), 64'(exp_b));
            check($sformatf("v%0d b%0d out_idx", id, k), 64'(out_idx), 64'(k));
            check($sformatf("v%0d b%0d out_last", id, k), 64'(out_last), 64'(k == v.n - 1));
            check($sformatf("v%0d b%0d in_ready", id, k), 64'(in_ready), 64'(k == v.n - 1));
            got[8*k +: 8] = out_byte;
            @(posedge clk); #1;
        end
        check($sformatf("v%0d done out_valid", id), 64'(out_valid), 64'd0);
        check($sformatf("v%0d round trip", id), 64'(decode(got, v.n, v.sgn)), 64'(v.value));
    endtask

    initial begin
        vecs[0]  = '{32'h00098765, 1'b0, 3, 40'h00_00_26_8E_E5};
        vecs[1]  = '{32'hFFFE1DC0, 1'b1, 3, 40'h00_00_78_BB_C0};
        vecs[2]  = '{32'h00000040, 1'b1, 2, 40'h00_00_00_00_C0};
        vecs[3]  = '{32'hFFFFFFC0, 1'b1, 1, 40'h00_00_00_00_40};
        vecs[4]  = '{32'h00000000, 1'b1, 1, 40'h00_00_00_00_00};
        vecs[5]  = '{32'h00000000, 1'b0, 1, 40'h00_00_00_00_00};
        vecs[6]  = '{32'hFFFFFFFF, 1'b1, 1, 40'h00_00_00_00_7F};
        vecs[7]  = '{32'hFFFFFFFF, 1'b0, 5, 40'h0F_FF_FF_FF_FF};
        vecs[8]  = '{32'h7FFFFFFF, 1'b1, 5, 40'h07_FF_FF_FF_FF};
        vecs[9]  = '{32'h80000000, 1'b1, 5, 40'h78_80_80_80_80};
        vecs[10] = '{32'h0000012C, 1'b0, 2, 40'h00_00_00_02_AC};
        vecs[11] = '{32'h0000007F, 1'b0, 1, 40'h00_00_00_00_7F};
        vecs[12] = '{32'h00000080, 1'b0, 2, 40'h00_00_00_01_80};
        vecs[13] = '{32'h0000003F, 1'b1, 1, 40'h00_00_00_00_3F};
        vecs[14] = '{32'hFFFFFFBF, 1'b1, 2, 40'h00_00_00_7F_BF};
        vecs[15] = '{32'h80000000, 1'b0, 5, 40'h08_80_80_80_80};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        value_in    = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_byte", 64'(out_byte), 64'd0);
        check("reset out_last", 64'(out_last), 64'd0);
        check("reset out_idx", 64'(out_idx), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Backpressure: unsigned 300 -> AC 02, stall 3 cycles on AC.
        in_valid = 1'b1; value_in = 32'd300; signed_mode = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; value_in = 32'h12345678; signed_mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp stall%0d out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("bp stall%0d out_byte", c), 64'(out_byte), 64'hAC);
            check($sformatf("bp stall%0d out_idx", c), 64'(out_idx), 64'd0);
            check($sformatf("bp stall%0d in_ready", c), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("bp release out_byte", 64'(out_byte), 64'hAC);
        @(posedge clk); #1;
        check("bp second out_byte", 64'(out_byte), 64'h02);
        check("bp second out_last", 64'(out_last), 64'd1);
        check("bp second out_idx", 64'(out_idx), 64'd1);
        @(posedge clk); #1;
        check("bp done out_valid", 64'(out_valid), 64'd0);

        // Back-to-back: unsigned 1 then unsigned 128 with in_valid held.
        in_valid = 1'b1; value_in = 32'd1; signed_mode = 1'b0;
        @(posedge clk); #1;
        check("b2b first out_byte", 64'(out_byte), 64'h01);
        check("b2b first out_last", 64'(out_last), 64'd1);
        check("b2b first in_ready", 64'(in_ready), 64'd1);
        value_in = 32'd128;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b second out_valid", 64'(out_valid), 64'd1);
        check("b2b second out_byte", 64'(out_byte), 64'h80);
        check("b2b second out_idx", 64'(out_idx), 64'd0);
        check("b2b second in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("b2b third out_valid", 64'(out_valid), 64'd1);
        check("b2b third out_byte", 64'(out_byte), 64'h01);
        check("b2b third out_idx", 64'(out_idx), 64'd1);
        check("b2b third out_last", 64'(out_last), 64'd1);
        @(posedge clk); #1;
        check("b2b done out_valid", 64'(out_valid), 64'd0);

        // Reset mid-stream after the first byte of unsigned 0xFFFFFFFF.
        in_valid = 1'b1; value_in = 32'hFFFFFFFF; signed_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst first out_byte", 64'(out_byte), 64'hFF);
        @(posedge clk); #1;
        check("rst second out_idx", 64'(out_idx), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst async out_valid", 64'(out_valid), 64'd0);
        check("rst async out_idx", 64'(out_idx), 64'd0);
        check("rst async in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst released out_valid", 64'(out_valid), 64'd0);
        run_vec('{32'd5, 1'b0, 1, 40'h00_00_00_00_05}, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/leb128_encode_stream.md
Name: leb128_encode_stream

Overview:
- Sequential LEB128 encoder: accepts one DATA_W-bit integer per transaction and emits its unsigned or signed LEB128 byte sequence, least significant group first, over a valid/ready byte stream.
- Sits on the write side of the WebAssembly datapath, where it serialises immediates and indices into the bytecode or output byte stream.
- Functional inverse of the existing LEB128 decode path: bytes it emits must decode back to the original value under the same signed/unsigned mode.

Parameters:
- DATA_W, 32, input value width; 32 and 64 supported.
- MAX_BYTES, ceil(DATA_W/7) (5 for 32, 10 for 64), derived, not overridable.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  value_in and signed_mode valid
- in_ready  output  1  encoder can accept a new value
- value_in  input  DATA_W  integer to encode
- signed_mode  input  1  0: unsigned LEB128; 1: signed LEB128
- out_valid  output  1  out_byte valid
- out_ready  input  1  downstream accepts out_byte
- out_byte  output  8  encoded byte; bit7 is the continuation flag
- out_last  output  1  current byte is the final byte of the encoding
- out_idx  output  4  0-based index of the current byte within the encoding

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, shift register=0, idx=0.
  - out_valid=0, out_byte=0, out_last=0, out_idx=0, in_ready=1.
- States:
  - IDLE: no encoding in progress.
  - EMIT: an encoding is being streamed.
- Accept (input handshake):
  - Occurs on in_valid && in_ready.
  - Latch value_in into shift register and latch signed_mode; set idx=0; go to EMIT.
  - First byte appears with out_valid=1 the next cycle (latency 1).
- Output:
  - out_byte, out_last and out_idx are driven from registers, so they are stable while out_valid && !out_ready.
- Per-byte rules, with g = shift_reg[6:0] and rem = shift_reg >> 7:
  - Shift is logical when unsigned, arithmetic when signed.
  - Unsigned: last when rem == 0.
  - Signed: last when (rem == 0 && g[6] == 0) or (rem == all-ones && g[6] == 1).
  - Forced last at idx == MAX_BYTES-1.
  - out_byte = {!last, g}.
- On out_valid && out_ready:
  - If not last: shift_reg <= rem, idx <= idx+1.
  - If last: return to IDLE.
- Final byte content for DATA_W=32:
  - Unsigned 5th byte carries value bits [31:28] zero-extended, i.e. 0x00-0x0F.
  - Signed 5th byte carries bits [31:28] sign-extended into 7 bits.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - Back-to-back transactions incur no bubble; an n-byte encoding occupies exactly n cycles at full throughput.
- Simultaneous last-byte handshake and new accept: the new value loads and the first byte of the new value is presented next cycle.
- value_in and signed_mode are ignored when not accepted; changing them during EMIT has no effect.
- Backpressure: out_ready may drop at any time; there is no limit on stall length and no data loss.
- Reset mid-stream: the encoding is aborted immediately, out_valid drops asynchronously, and no partial continuation resumes after release.
- Byte counts:
  - Zero encodes as the single byte 0x00 in both modes.
  - Signed -1 encodes as the single byte 0x7F.
  - Maximum length is MAX_BYTES.

Decomposition:
- Shared package leb128_pkg holds:
  - LEB128_GROUP_W=7 and LEB128_CONT_BIT=7.
  - Function leb128_max_bytes(width).
  - Typedef leb128_idx_t (4 bits).
  - A state enum {LEB_IDLE, LEB_EMIT}.
- Natural sub-module: leb128_group_step (combinational). Inputs shift_reg, signed_mode, idx; outputs g, rem and last. It is reusable by a future parallel encoder and unit-testable against the decoder.

Test Plan:
- Unsigned 624485 (0x00098765), out_ready=1 → E5, 8E, 26; out_idx 0,1,2; out_last only on 26; in_ready high again in the 26 handshake cycle.
- Signed: -123456 (0xFFFE1DC0) → C0, BB, 78; 64 → C0, 00; -64 → 40; 0 → 00; -1 → 7F.
- Unsigned 0xFFFFFFFF → FF FF FF FF 0F; signed 0x7FFFFFFF → FF FF FF FF 07; signed 0x80000000 → 80 80 80 80 78 (5 bytes, forced last).
- Backpressure: encode unsigned 300 (AC 02), hold out_ready=0 for 3 cycles on byte AC → out_byte=AC, out_valid=1 and out_idx=0 stable throughout; 02 follows after release.
- Back-to-back: in_valid held with unsigned 1 then unsigned 128 → 01, 80, 01 on three consecutive cycles with out_valid continuous.
- Reset: assert rst_n=0 after the first byte of 0xFFFFFFFF → out_valid=0 immediately. After release, in_ready=1 and encoding unsigned 5 yields the single byte 05. Round-trip all cases through the existing decoder for a match.
